// File: rtl/gem_copad_selftrig_if.sv
// gem_copad_selftrig_if: co-pad finder inputs, trigger controls and trigger/dump/counter outputs (feb_mask only with GEM_SELFTRIG_FEB_MASK_EN)
interface gem_copad_selftrig_if #(
  parameter int MXCLUSTERS = 8,
  parameter int MXCLSTB    = 14,
  parameter int MXFEB      = 24,
  parameter int MXCNTB     = 16
);
  logic [MXCLUSTERS-1:0]         match;
  logic                          any_match;
  logic [MXCLSTB-1:0]            cluster [MXCLUSTERS];
  logic [MXFEB-1:0]              active_feb_list;
  logic                          trig_en;
  logic [7:0]                    prescale;
  logic [3:0]                    deadtime;
  logic [3:0]                    min_nmatch;
  logic                          cnt_clear;
`ifdef GEM_SELFTRIG_FEB_MASK_EN
  logic [MXFEB-1:0]              feb_mask;
`endif
  logic                          gem_self_trig;
  logic [MXFEB-1:0]              trig_feb_list;
  logic                          clst_vld;
  logic [MXCLSTB-1:0]            clst_data;
  logic [$clog2(MXCLUSTERS)-1:0] clst_idx;
  logic                          clst_last;
  logic                          busy;
  logic [MXCNTB-1:0]             match_cnt;
  logic [MXCNTB-1:0]             trig_cnt;
  modport master (
    output match, any_match, cluster, active_feb_list, trig_en, prescale, deadtime, min_nmatch, cnt_clear,
`ifdef GEM_SELFTRIG_FEB_MASK_EN
    output feb_mask,
`endif
    input  gem_self_trig, trig_feb_list, clst_vld, clst_data, clst_idx, clst_last, busy, match_cnt, trig_cnt
  );
  modport slave (
    input  match, any_match, cluster, active_feb_list, trig_en, prescale, deadtime, min_nmatch, cnt_clear,
`ifdef GEM_SELFTRIG_FEB_MASK_EN
    input  feb_mask,
`endif
    output gem_self_trig, trig_feb_list, clst_vld, clst_data, clst_idx, clst_last, busy, match_cnt, trig_cnt
  );
endinterface

// File: rtl/gem_copad_selftrig.sv
// gem_copad_selftrig: prescaled, dead-timed GEM self-trigger with serial matched-cluster dump and saturating counters (optional FEB mask: GEM_SELFTRIG_FEB_MASK_EN)
module gem_copad_selftrig (
  input logic              clock,
  input logic              global_reset,
  gem_copad_selftrig_if.slave bus
);
  localparam int MXCLUSTERS = 8;
  localparam int MXCLSTB    = 14;
  localparam int MXFEB      = 24;
  localparam int MXCNTB     = 16;
  localparam int IW         = $clog2(MXCLUSTERS);
  localparam int CW         = $clog2(MXCLUSTERS + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DEAD = 2'd2;
  logic [1:0]            state;
  logic [7:0]            psc;
  logic [MXCLUSTERS-1:0] mask;
  logic [MXCLUSTERS-1:0] mask_nxt;
  logic [MXCLUSTERS-1:0] m_eff;
  logic [3:0]            dcnt;
  logic [MXCLSTB-1:0]    clst_q [MXCLUSTERS];
  logic [CW-1:0]         nmatch;
  logic [3:0]            thr;
  logic [IW-1:0]         low_idx;
  logic [MXFEB-1:0]      feb_en;
  logic                  feb_ok;
  logic                  cand;
  logic                  fire;
`ifdef GEM_SELFTRIG_FEB_MASK_EN
  assign feb_en = bus.active_feb_list & ~bus.feb_mask;
  assign feb_ok = |feb_en;
`else
  assign feb_en = bus.active_feb_list;
  assign feb_ok = 1'b1;
`endif
  assign bus.busy = state != IDLE;
  // candidate qualification, prescale decision and next dump slot
  always_comb begin
    m_eff = bus.match & {MXCLUSTERS{bus.any_match}};
    nmatch = '0;
    for (int i = 0; i < MXCLUSTERS; i++) nmatch = nmatch + CW'(m_eff[i]);
    thr = bus.min_nmatch == 4'd0 ? 4'd1 : bus.min_nmatch;
    cand = bus.trig_en & bus.any_match & (4'(nmatch) >= thr) & (state == IDLE) & feb_ok;
    fire = cand & (psc >= bus.prescale);
    low_idx = '0;
    for (int i = MXCLUSTERS - 1; i >= 0; i--) if (mask[i]) low_idx = IW'(i);
    mask_nxt = mask & (mask - 1'b1);
  end
  // trigger FSM: fire from IDLE, dump lowest mask bit per clock, then dead time
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      state <= IDLE;
      psc <= '0;
      mask <= '0;
      dcnt <= '0;
      bus.gem_self_trig <= 1'b0;
      bus.trig_feb_list <= '0;
      bus.clst_vld <= 1'b0;
      bus.clst_data <= '0;
      bus.clst_idx <= '0;
      bus.clst_last <= 1'b0;
    end else begin
      bus.gem_self_trig <= fire;
      bus.clst_vld <= 1'b0;
      bus.clst_last <= 1'b0;
      if (cand) psc <= fire ? 8'd0 : psc + 8'd1;
      case (state)
        IDLE: if (fire) begin
          state <= DUMP;
          mask <= m_eff;
          bus.trig_feb_list <= feb_en;
        end
        DUMP: begin
          bus.clst_vld <= 1'b1;
          bus.clst_idx <= low_idx;
          bus.clst_data <= clst_q[low_idx];
          bus.clst_last <= mask_nxt == '0;
          mask <= mask_nxt;
          if (mask_nxt == '0) begin
            state <= bus.deadtime == 4'd0 ? IDLE : DEAD;
            dcnt <= bus.deadtime;
          end
        end
        DEAD: begin
          dcnt <= dcnt - 4'd1;
          if (dcnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // snapshot of the cluster words taken on the firing clock
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) clst_q <= '{default: '0};
    else if (fire) clst_q <= bus.cluster;
  end
  // saturating match/trigger counters, clear wins over increment
  always_ff @(posedge clock or posedge global_reset) begin
    if (global_reset) begin
      bus.match_cnt <= '0;
      bus.trig_cnt <= '0;
    end else begin
      bus.match_cnt <= bus.cnt_clear ? '0 : (bus.any_match && bus.match_cnt != '1) ? bus.match_cnt + MXCNTB'(1) : bus.match_cnt;
      bus.trig_cnt <= bus.cnt_clear ? '0 : (fire && bus.trig_cnt != '1) ? bus.trig_cnt + MXCNTB'(1) : bus.trig_cnt;
    end
  end
endmodule
